// File: rtl/bitlet_pe_array.sv
// Bitlet PE array: N_lane lanes share one activation stream, each with its
// own weights; masked lane results are serialized with backpressure.
`ifndef Wid_bin
`define Wid_bin 16
`endif
`ifndef Wid_exp
`define Wid_exp 2
`endif
`ifndef Wid_abs
`define Wid_abs 4
`endif
`ifndef Wid_quant
`define Wid_quant 4
`endif
`ifndef Max_quant
`define Max_quant 3
`endif

package bitlet_pkg;
  localparam int NC_W  = 16;
  localparam int ACC_W = 32;

  typedef struct packed {
    logic                  isfix;
    logic                  relu;
    logic [`Wid_quant-1:0] quant;
    logic [`Max_quant-1:0] prune;
    logic [NC_W-1:0]       ncalc;
  } cfg_t;
endpackage

module bitlet_pe_lane
  import bitlet_pkg::*;
#(
  parameter int N_total = 64,
  parameter int N_input = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  cfg_t                         cfg,
  input  logic [N_total-1:0]           w_sig,
  input  logic [N_total*`Wid_exp-1:0]  w_exp,
  input  logic [N_total*`Wid_abs-1:0]  w_abs,
  input  logic                         abin_vld,
  input  logic [N_input*`Wid_bin-1:0]  abin_vec,
  output logic                         res_vld,
  output logic [`Wid_bin-1:0]          res
);
  localparam int N_BEAT = N_total / N_input;
  localparam int BW = N_BEAT > 1 ? $clog2(N_BEAT) : 1;
  localparam int WB = `Wid_bin;
  localparam int WE = `Wid_exp;
  localparam int WA = `Wid_abs;
  localparam int WM = WA + (1 << WE) - 1;
  localparam logic signed [ACC_W-1:0] SMAX =
    ACC_W'((1 << (WB - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = -SMAX - 1;

  logic [BW-1:0] bcnt;
  logic signed [ACC_W-1:0] acc, psum, total, shd;
  logic [WB-1:0] fin;
  logic last;

  logic signed [WM:0] wmat [N_BEAT][N_input];
  logic signed [ACC_W-1:0] term [N_input];

  // Signed weight per input; pruned bits and inputs past ncalc read as zero
  for (genvar k = 0; k < N_total; k++) begin : g_w
    logic [WA-1:0] mag;
    logic [WM-1:0] shf;
    logic signed [WM:0] pos;
    assign mag = w_abs[k*WA +: WA] & ({WA{1'b1}} << cfg.prune);
    assign shf = WM'(mag) << w_exp[k*WE +: WE];
    assign pos = $signed({1'b0, shf});
    assign wmat[k/N_input][k%N_input] =
      (NC_W'(k) <= cfg.ncalc) ? (w_sig[k] ? -pos : pos) : '0;
  end

  for (genvar j = 0; j < N_input; j++) begin : g_t
    logic [WB-1:0] a;
    logic signed [WM:0] ws;
    logic signed [ACC_W-1:0] av, wv;
    assign a  = abin_vec[j*WB +: WB];
    assign ws = wmat[bcnt][j];
    assign av = cfg.isfix ? {{(ACC_W-WB){a[WB-1]}}, a}
                          : {{(ACC_W-WB){1'b0}}, a};
    assign wv = {{(ACC_W-WM-1){ws[WM]}}, ws};
    assign term[j] = av * wv;
  end

  assign last = bcnt == BW'(N_BEAT - 1);

  always_comb begin
    psum = '0;
    for (int j = 0; j < N_input; j++) begin
      psum = psum + term[j];
    end
    total = acc + psum;
    shd = total >>> cfg.quant;
    if (cfg.relu && shd < 0) fin = '0;
    else if (shd > SMAX) fin = WB'(SMAX);
    else if (shd < SMIN) fin = WB'(SMIN);
    else fin = shd[WB-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt    <= '0;
      acc     <= '0;
      res_vld <= 1'b0;
      res     <= '0;
    end else begin
      res_vld <= 1'b0;
      if (flush) begin
        bcnt <= '0;
        acc  <= '0;
      end else if (abin_vld) begin
        if (last) begin
          bcnt    <= '0;
          acc     <= '0;
          res_vld <= 1'b1;
          res     <= fin;
        end else begin
          bcnt <= bcnt + 1'b1;
          acc  <= total;
        end
      end
    end
  end
endmodule

module bitlet_pe_array
  import bitlet_pkg::*;
#(
  parameter int N_lane  = 4,
  parameter int N_total = 64,
  parameter int N_input = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 job_vld,
  output logic                                 job_rdy,
  input  logic [N_lane-1:0]                    job_mask,
  input  logic                                 job_isfix,
  input  logic                                 job_relu,
  input  logic [`Wid_quant-1:0]                job_quant,
  input  logic [`Max_quant-1:0]                job_prune,
  input  logic [$clog2(N_total)-1:0]           job_ncalc,
  input  logic [N_lane*N_total-1:0]            job_Wsig,
  input  logic [N_lane*N_total*`Wid_exp-1:0]   job_Wexp,
  input  logic [N_lane*N_total*`Wid_abs-1:0]   job_Wabs,
  input  logic                                 act_vld,
  output logic                                 act_rdy,
  input  logic [N_input*`Wid_bin-1:0]          act_vec,
  output logic                                 res_vld,
  input  logic                                 res_rdy,
  output logic [(N_lane>1?$clog2(N_lane):1)-1:0] res_lane,
  output logic [`Wid_bin-1:0]                  res,
  output logic                                 done,
  output logic                                 err
);
  localparam int LW = N_lane > 1 ? $clog2(N_lane) : 1;
  localparam int N_BEAT = N_total / N_input;
  localparam int BW = N_BEAT > 1 ? $clog2(N_BEAT) : 1;
  localparam int WB = `Wid_bin;
  localparam int WE = `Wid_exp;
  localparam int WA = `Wid_abs;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;
  state_t state_q, state_d;

  logic [N_lane-1:0] mask_q, flag_q, rem_q;
  cfg_t cfg_q;
  logic [N_lane*N_total-1:0] wsig_q;
  logic [N_lane*N_total*WE-1:0] wexp_q;
  logic [N_lane*N_total*WA-1:0] wabs_q;
  logic flush_q, act_rdy_q, job_rdy_q;
  logic [BW-1:0] beat_q;
  logic [WB-1:0] cap_q [N_lane];
  logic res_vld_q, done_q, err_q;
  logic [LW-1:0] res_lane_q;
  logic [WB-1:0] res_q;

  logic [N_lane-1:0] lane_vld;
  logic [WB-1:0] lane_res [N_lane];

  logic job_acc, act_acc, last_beat, res_acc;
  logic all_cap, cap_en, drain_end, load_res;
  logic [N_lane-1:0] src, pick_oh;
  logic [LW-1:0] pick;

  function automatic logic [LW-1:0] first_set(
    input logic [N_lane-1:0] v
  );
    first_set = '0;
    for (int i = N_lane - 1; i >= 0; i--) begin
      if (v[i]) first_set = LW'(i);
    end
  endfunction

  assign job_acc   = job_vld && job_rdy_q;
  assign act_acc   = act_vld && act_rdy_q;
  assign last_beat = act_acc && (beat_q == BW'(N_BEAT - 1));
  assign res_acc   = res_vld_q && res_rdy;
  assign all_cap   = (flag_q & mask_q) == mask_q;
  assign cap_en    = state_q == LOAD || state_q == COMPUTE;
  assign drain_end = state_q == DRAIN &&
                     (!res_vld_q || (res_acc && rem_q == '0));
  assign load_res  = (state_q == COMPUTE && all_cap) ||
                     (state_q == DRAIN && res_acc);
  assign src       = state_q == DRAIN ? rem_q : mask_q;
  assign pick      = first_set(src);
  assign pick_oh   = N_lane'(1) << pick;

  for (genvar i = 0; i < N_lane; i++) begin : g_lane
    bitlet_pe_lane #(
      .N_total(N_total),
      .N_input(N_input)
    ) u_pe (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush_q),
      .cfg      (cfg_q),
      .w_sig    (wsig_q[i*N_total +: N_total]),
      .w_exp    (wexp_q[i*N_total*WE +: N_total*WE]),
      .w_abs    (wabs_q[i*N_total*WA +: N_total*WA]),
      .abin_vld (act_acc && mask_q[i]),
      .abin_vec (act_vec),
      .res_vld  (lane_vld[i]),
      .res      (lane_res[i])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (job_acc) state_d = LOAD;
      LOAD:    if (last_beat) state_d = COMPUTE;
      COMPUTE: if (all_cap) state_d = DRAIN;
      DRAIN:   if (drain_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Job config and weights stay frozen until the job returns to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      cfg_q  <= '0;
      wsig_q <= '0;
      wexp_q <= '0;
      wabs_q <= '0;
    end else if (job_acc) begin
      mask_q      <= job_mask;
      cfg_q.isfix <= job_isfix;
      cfg_q.relu  <= job_relu;
      cfg_q.quant <= job_quant;
      cfg_q.prune <= job_prune;
      cfg_q.ncalc <= NC_W'(job_ncalc);
      wsig_q      <= job_Wsig;
      wexp_q      <= job_Wexp;
      wabs_q      <= job_Wabs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      flush_q    <= 1'b0;
      act_rdy_q  <= 1'b0;
      job_rdy_q  <= 1'b0;
      beat_q     <= '0;
      flag_q     <= '0;
      rem_q      <= '0;
      res_vld_q  <= 1'b0;
      res_lane_q <= '0;
      res_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < N_lane; i++) cap_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      flush_q   <= job_acc;
      job_rdy_q <= state_d == IDLE;
      done_q    <= drain_end;
      if (job_acc) beat_q <= '0;
      else if (act_acc) beat_q <= last_beat ? '0 : beat_q + 1'b1;
      if (flush_q) act_rdy_q <= 1'b1;
      else if (last_beat) act_rdy_q <= 1'b0;
      for (int i = 0; i < N_lane; i++) begin
        if (lane_vld[i]) begin
          if (cap_en && mask_q[i] && !flag_q[i]) begin
            cap_q[i]  <= lane_res[i];
            flag_q[i] <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        end
      end
      if (drain_end) flag_q <= '0;
      // Next masked lane is preloaded so handshakes run back-to-back
      if (load_res) begin
        res_vld_q <= |src;
        rem_q     <= src & ~pick_oh;
        if (|src) begin
          res_q      <= cap_q[pick];
          res_lane_q <= pick;
        end
      end
    end
  end

  assign job_rdy  = job_rdy_q;
  assign act_rdy  = act_rdy_q;
  assign res_vld  = res_vld_q;
  assign res_lane = res_lane_q;
  assign res      = res_q;
  assign done     = done_q;
  assign err      = err_q;
endmodule

// File: tb/tb_bitlet_pe_array.sv
// Directed bench for bitlet_pe_array with a lane-result scoreboard
// fed from a behavioural dot-product model.
module tb_bitlet_pe_array;
  localparam int NL = 4, NT = 64, NI = 16, NB = NT / NI;
  localparam int WB = 16, WE = 2, WA = 4, WQ = 4, MQ = 3;
  localparam int NCW = 6, LW = 2, LIM = 300;

  logic clk, rst_n;
  logic job_vld, job_rdy, job_isfix, job_relu;
  logic [NL-1:0] job_mask;
  logic [WQ-1:0] job_quant;
  logic [MQ-1:0] job_prune;
  logic [NCW-1:0] job_ncalc;
  logic [NL*NT-1:0] job_Wsig;
  logic [NL*NT*WE-1:0] job_Wexp;
  logic [NL*NT*WA-1:0] job_Wabs;
  logic act_vld, act_rdy;
  logic [NI*WB-1:0] act_vec;
  logic res_vld, res_rdy, done, err;
  logic [LW-1:0] res_lane;
  logic [WB-1:0] res;

  bitlet_pe_array #(.N_lane(NL), .N_total(NT), .N_input(NI)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_vld(job_vld), .job_rdy(job_rdy), .job_mask(job_mask),
    .job_isfix(job_isfix), .job_relu(job_relu),
    .job_quant(job_quant), .job_prune(job_prune),
    .job_ncalc(job_ncalc), .job_Wsig(job_Wsig),
    .job_Wexp(job_Wexp), .job_Wabs(job_Wabs),
    .act_vld(act_vld), .act_rdy(act_rdy), .act_vec(act_vec),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_lane(res_lane),
    .res(res), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int lane;
    logic [WB-1:0] val;
  } exp_t;
  exp_t sbq[$];

  int nvec = 0, nfail = 0;
  logic w_sig_a [NL][NT];
  logic [WE-1:0] w_exp_a [NL][NT];
  logic [WA-1:0] w_abs_a [NL][NT];
  logic [WB-1:0] acts [NT];
  int j_isfix, j_relu, j_quant, j_prune, j_ncalc;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WB-1:0] golden(int l);
    longint acc, a;
    int m, w;
    acc = 0;
    for (int k = 0; k < NT; k++) begin
      if (k <= j_ncalc) begin
        m = int'(w_abs_a[l][k]) & ((15 << j_prune) & 15);
        w = m << int'(w_exp_a[l][k]);
        if (w_sig_a[l][k]) w = -w;
        if (j_isfix != 0) a = longint'($signed(acts[k]));
        else a = longint'({48'd0, acts[k]});
        acc += a * longint'(w);
      end
    end
    acc = acc >>> j_quant;
    if (j_relu != 0 && acc < 0) acc = 0;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc[WB-1:0];
  endfunction

  task automatic gen_unit();
    for (int l = 0; l < NL; l++)
      for (int k = 0; k < NT; k++) begin
        w_sig_a[l][k] = 1'b0;
        w_exp_a[l][k] = '0;
        w_abs_a[l][k] = WA'(1);
      end
    for (int k = 0; k < NT; k++) acts[k] = 16'h0100;
  endtask

  task automatic gen_rand(input bit big);
    for (int l = 0; l < NL; l++)
      for (int k = 0; k < NT; k++) begin
        w_sig_a[l][k] = 1'($urandom_range(0, 1));
        w_exp_a[l][k] = WE'($urandom_range(0, 3));
        w_abs_a[l][k] = WA'($urandom_range(0, 15));
      end
    for (int k = 0; k < NT; k++)
      acts[k] = big ? WB'($urandom) : WB'($urandom_range(0, 511) - 256);
  endtask

  task automatic send_job(input logic [NL-1:0] m, input int isfix,
                          input int relu, input int quant,
                          input int prune, input int ncalc);
    int t;
    j_isfix = isfix; j_relu = relu; j_quant = quant;
    j_prune = prune; j_ncalc = ncalc;
    for (int l = 0; l < NL; l++)
      for (int k = 0; k < NT; k++) begin
        job_Wsig[l*NT+k] = w_sig_a[l][k];
        job_Wexp[(l*NT+k)*WE +: WE] = w_exp_a[l][k];
        job_Wabs[(l*NT+k)*WA +: WA] = w_abs_a[l][k];
      end
    job_mask = m; job_isfix = 1'(isfix); job_relu = 1'(relu);
    job_quant = WQ'(quant); job_prune = MQ'(prune);
    job_ncalc = NCW'(ncalc);
    for (int l = 0; l < NL; l++)
      if (m[l]) sbq.push_back('{l, golden(l)});
    t = 0;
    while (!job_rdy && t < LIM) begin
      @(negedge clk);
      t++;
    end
    check("job_rdy_wait", t < LIM, 1);
    job_vld = 1'b1;
    @(negedge clk);
    job_vld = 1'b0;
    check("job_rdy_busy", job_rdy, 0);
  endtask

  task automatic send_beats(input int g0, input int g1,
                            input int g2, input int g3);
    int g[4];
    int t;
    g = '{g0, g1, g2, g3};
    for (int b = 0; b < NB; b++) begin
      act_vld = 1'b0;
      repeat (g[b]) @(negedge clk);
      for (int j = 0; j < NI; j++) act_vec[j*WB +: WB] = acts[b*NI+j];
      act_vld = 1'b1;
      t = 0;
      while (!act_rdy && t < LIM) begin
        @(negedge clk);
        t++;
      end
      check("act_rdy_wait", t < LIM, 1);
      @(negedge clk);
      act_vld = 1'b0;
    end
    check("act_rdy_drop", act_rdy, 0);
  endtask

  task automatic collect(input int stall_lane, input int stall_n,
                         input bit b2b);
    int last_hs, stalled;
    bit seen;
    logic [WB-1:0] h_res;
    logic [LW-1:0] h_lane;
    exp_t e;
    last_hs = -1; stalled = 0; seen = 0;
    h_res = '0; h_lane = '0;
    for (int t = 0; t < LIM && !seen; t++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        res_rdy = 1'b1;
        check("done_job_rdy", job_rdy, 1);
        check("done_res_vld", res_vld, 0);
      end else if (res_vld) begin
        if (int'(res_lane) == stall_lane && stalled < stall_n) begin
          if (stalled == 0) begin
            h_res = res;
            h_lane = res_lane;
          end else begin
            check("hold_res", res, h_res);
            check("hold_lane", res_lane, h_lane);
          end
          stalled++;
          res_rdy = 1'b0;
        end else begin
          res_rdy = 1'b1;
          check("extra_result", sbq.size() > 0, 1);
          if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("res_lane", res_lane, e.lane);
            check("res_val", res, e.val);
          end
          if (b2b && last_hs >= 0) check("b2b_gap", t - last_hs, 1);
          last_hs = t;
        end
      end else begin
        res_rdy = 1'b1;
      end
    end
    res_rdy = 1'b1;
    check("done_seen", seen, 1);
    check("stall_cycles", stalled, stall_n);
    check("sb_empty", sbq.size(), 0);
    @(negedge clk);
    check("done_pulse_1cyc", done, 0);
    check("err_clear", err, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_job_rdy"}, job_rdy, 0);
    check({tag, "_act_rdy"}, act_rdy, 0);
    check({tag, "_res_vld"}, res_vld, 0);
    check({tag, "_res_lane"}, res_lane, 0);
    check({tag, "_res"}, res, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    rst_n = 1'b0; job_vld = 1'b0; act_vld = 1'b0; res_rdy = 1'b1;
    job_mask = '0; job_isfix = 1'b0; job_relu = 1'b0;
    job_quant = '0; job_prune = '0; job_ncalc = '0;
    job_Wsig = '0; job_Wexp = '0; job_Wabs = '0; act_vec = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_job_rdy", job_rdy, 1);

    gen_unit();
    send_job(4'b1111, 1, 0, 8, 0, 63);
    check("unit_golden", sbq[0].val, 16'd64);
    send_beats(0, 0, 0, 0);
    collect(-1, 0, 1);

    gen_rand(0);
    send_job(4'b0101, 1, 0, 4, 0, 63);
    send_beats(0, 0, 0, 0);
    collect(-1, 0, 1);

    gen_rand(0);
    send_job(4'b1111, 1, 0, 5, 0, 63);
    send_beats(0, 0, 0, 0);
    collect(1, 3, 0);

    send_job(4'b1111, 1, 0, 5, 0, 63);
    send_beats(0, 2, 0, 4);
    collect(-1, 0, 1);

    send_job(4'b0000, 1, 0, 5, 0, 63);
    send_beats(0, 0, 0, 0);
    collect(-1, 0, 0);

    gen_rand(1);
    send_job(4'b1010, 0, 1, 10, 2, 40);
    send_beats(1, 0, 3, 0);
    collect(-1, 0, 1);

    gen_rand(0);
    send_job(4'b1111, 1, 0, 4, 0, 63);
    send_beats(0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    gen_rand(0);
    send_job(4'b1111, 1, 1, 3, 1, 50);
    send_beats(0, 1, 0, 0);
    collect(-1, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
